// File: rtl/bouncing_sprite.sv
// Single sprite that draws itself and moves by a set velocity once per frame.
// It reflects off the screen edges and can flash a second colour for a timed number of frames.
module bouncing_sprite #(
    parameter int          WIDTH        = 64,
    parameter int          HEIGHT       = 64,
    parameter logic [23:0] COLOR        = 24'hFF_FF_FF,
    parameter logic [23:0] FLASH_COLOR  = 24'hFF_00_00,
    parameter int          FLASH_FRAMES = 8,
    parameter int          OUTLINE      = 0,
    parameter int          BORDER       = 2,
    parameter int          SCREEN_W     = 1024,
    parameter int          SCREEN_H     = 768,
    parameter int          INIT_X       = 0,
    parameter int          INIT_Y       = 0
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        vsync,
    input  logic        enable,
    input  logic [3:0]  speed_x,
    input  logic [3:0]  speed_y,
    input  logic        hit,
    output logic [23:0] pixel,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        bounce
);
    typedef enum logic {DIR_FWD, DIR_REV} dir_t;  // FWD = right/down, REV = left/up

    localparam logic [11:0] MAX_X = 12'(SCREEN_W - WIDTH);
    localparam logic [10:0] MAX_Y = 11'(SCREEN_H - HEIGHT);

    logic [10:0] r_x;
    logic [9:0]  r_y;
    dir_t        r_dir_x;
    dir_t        r_dir_y;
    logic        r_vsync_d;
    logic [7:0]  r_flash_cnt;
    logic [23:0] r_pixel;
    logic        r_bounce;

    logic        w_tick;
    logic [11:0] w_sum_x;
    logic [10:0] w_sum_y;
    logic [10:0] w_x_nxt;
    logic [9:0]  w_y_nxt;
    dir_t        w_dir_x_nxt;
    dir_t        w_dir_y_nxt;
    logic        w_bx;
    logic        w_by;
    logic [11:0] w_h;
    logic [11:0] w_x_ext;
    logic [10:0] w_v;
    logic [10:0] w_y_ext;
    logic        w_in_box;
    logic        w_on_edge;
    logic        w_draw;
    logic [23:0] w_color;

    assign w_tick = r_vsync_d & ~vsync;

    // Speed 0 is excluded up front so a sprite resting on an edge never pulses bounce.
    always_comb begin
        w_sum_x     = {1'b0, r_x} + {8'd0, speed_x};
        w_x_nxt     = r_x;
        w_dir_x_nxt = r_dir_x;
        w_bx        = 1'b0;
        if (speed_x != '0) begin
            if (r_dir_x == DIR_FWD) begin
                if (w_sum_x >= MAX_X) begin
                    w_x_nxt     = MAX_X[10:0];
                    w_dir_x_nxt = DIR_REV;
                    w_bx        = 1'b1;
                end else begin
                    w_x_nxt = w_sum_x[10:0];
                end
            end else begin
                if ({1'b0, r_x} <= {8'd0, speed_x}) begin
                    w_x_nxt     = '0;
                    w_dir_x_nxt = DIR_FWD;
                    w_bx        = 1'b1;
                end else begin
                    w_x_nxt = r_x - {7'd0, speed_x};
                end
            end
        end
    end

    always_comb begin
        w_sum_y     = {1'b0, r_y} + {7'd0, speed_y};
        w_y_nxt     = r_y;
        w_dir_y_nxt = r_dir_y;
        w_by        = 1'b0;
        if (speed_y != '0) begin
            if (r_dir_y == DIR_FWD) begin
                if (w_sum_y >= MAX_Y) begin
                    w_y_nxt     = MAX_Y[9:0];
                    w_dir_y_nxt = DIR_REV;
                    w_by        = 1'b1;
                end else begin
                    w_y_nxt = w_sum_y[9:0];
                end
            end else begin
                if ({1'b0, r_y} <= {7'd0, speed_y}) begin
                    w_y_nxt     = '0;
                    w_dir_y_nxt = DIR_FWD;
                    w_by        = 1'b1;
                end else begin
                    w_y_nxt = r_y - {6'd0, speed_y};
                end
            end
        end
    end

    always_comb begin
        w_h       = {1'b0, hcount};
        w_x_ext   = {1'b0, r_x};
        w_v       = {1'b0, vcount};
        w_y_ext   = {1'b0, r_y};
        w_in_box  = (w_h >= w_x_ext) && (w_h < w_x_ext + 12'(WIDTH)) &&
                    (w_v >= w_y_ext) && (w_v < w_y_ext + 11'(HEIGHT));
        w_on_edge = (w_h <  w_x_ext + 12'(BORDER)) ||
                    (w_h >= w_x_ext + 12'(WIDTH - BORDER)) ||
                    (w_v <  w_y_ext + 11'(BORDER)) ||
                    (w_v >= w_y_ext + 11'(HEIGHT - BORDER));
        w_draw    = w_in_box;
        if (OUTLINE != 0) begin
            w_draw = w_in_box && w_on_edge;
        end
        w_color = (r_flash_cnt != '0) ? FLASH_COLOR : COLOR;
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_x         <= 11'(INIT_X);
            r_y         <= 10'(INIT_Y);
            r_dir_x     <= DIR_FWD;
            r_dir_y     <= DIR_FWD;
            r_vsync_d   <= 1'b1;
            r_flash_cnt <= '0;
            r_pixel     <= '0;
            r_bounce    <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_bounce  <= 1'b0;
            if (w_tick && enable) begin
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_dir_x  <= w_dir_x_nxt;
                r_dir_y  <= w_dir_y_nxt;
                r_bounce <= w_bx | w_by;
            end
            if (hit) begin
                r_flash_cnt <= 8'(FLASH_FRAMES);
            end else if (w_tick && (r_flash_cnt != '0)) begin
                r_flash_cnt <= r_flash_cnt - 8'd1;
            end
            r_pixel <= w_draw ? w_color : '0;
        end
    end

    assign pixel  = r_pixel;
    assign x      = r_x;
    assign y      = r_y;
    assign bounce = r_bounce;
endmodule

// File: tb/tb_bouncing_sprite.sv
// Scoreboard bench for bouncing_sprite: five instances with different parameter sets share the stimulus.
// Expected values are queued at stimulus time and popped when the DUT output is sampled.
module tb_bouncing_sprite;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        vsync = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  speed_x = '0;
    logic [3:0]  speed_y = '0;
    logic        hit = 1'b0;

    logic [23:0] pix [5];
    logic [10:0] xo  [5];
    logic [9:0]  yo  [5];
    logic        bo  [5];

    logic [4:0]  bfirst;
    logic [4:0]  bsecond;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bouncing_sprite #(.INIT_X(100), .INIT_Y(50)) dut_a (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
        .enable(enable), .speed_x(speed_x), .speed_y(speed_y), .hit(hit),
        .pixel(pix[0]), .x(xo[0]), .y(yo[0]), .bounce(bo[0]));
    bouncing_sprite #(.INIT_X(958), .INIT_Y(0)) dut_b (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
        .enable(enable), .speed_x(speed_x), .speed_y(speed_y), .hit(hit),
        .pixel(pix[1]), .x(xo[1]), .y(yo[1]), .bounce(bo[1]));
    bouncing_sprite #(.SCREEN_W(74), .SCREEN_H(74), .INIT_X(10), .INIT_Y(10)) dut_c (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
        .enable(enable), .speed_x(speed_x), .speed_y(speed_y), .hit(hit),
        .pixel(pix[2]), .x(xo[2]), .y(yo[2]), .bounce(bo[2]));
    bouncing_sprite #(.FLASH_FRAMES(2)) dut_d (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
        .enable(enable), .speed_x(speed_x), .speed_y(speed_y), .hit(hit),
        .pixel(pix[3]), .x(xo[3]), .y(yo[3]), .bounce(bo[3]));
    bouncing_sprite #(.OUTLINE(1), .BORDER(2)) dut_e (
        .vclock(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
        .enable(enable), .speed_x(speed_x), .speed_y(speed_y), .hit(hit),
        .pixel(pix[4]), .x(xo[4]), .y(yo[4]), .bounce(bo[4]));

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; vsync = 1'b1; hit = 1'b0; enable = 1'b0;
        speed_x = '0; speed_y = '0; hcount = '0; vcount = '0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // vsync low for 2 + extra_low cycles; bounce sampled on the two cycles after the fall
    task automatic tick(input int extra_low);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk); #1;
        bfirst = {bo[4], bo[3], bo[2], bo[1], bo[0]};
        @(posedge clk); #1;
        bsecond = {bo[4], bo[3], bo[2], bo[1], bo[0]};
        repeat (extra_low) @(posedge clk);
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int          hs [5] = '{100, 164, 163, 99, 100};
        int          vs [5] = '{50, 50, 113, 50, 114};
        logic [23:0] ps [5] = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h0};
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(32'd100); exp_q.push_back(32'd50);
        exp_q.push_back(32'd0);   exp_q.push_back(32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); checks++;
        if (32'(xo[0]) !== e) begin errors++; $display("FAIL reset_x got %0d want %0d", xo[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(yo[0]) !== e) begin errors++; $display("FAIL reset_y got %0d want %0d", yo[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(pix[0]) !== e) begin errors++; $display("FAIL reset_pixel got %h want %h", pix[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(bo[0]) !== e) begin errors++; $display("FAIL reset_bounce got %0d want %0d", bo[0], e); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hcount = 11'(hs[i]); vcount = 10'(vs[i]);
            exp_q.push_back(32'(ps[i]));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (32'(pix[0]) !== e)
                begin errors++; $display("FAIL reset_pix[%0d] got %h want %h", i, pix[0], e); end
        end
    endtask

    task automatic test_motion();
        int          ex [5] = '{103, 106, 109, 112, 112};
        int          ey [5] = '{52, 54, 56, 58, 58};
        int          hs [4] = '{112, 111, 175, 176};
        logic [23:0] ps [4] = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0};
        do_reset();
        speed_x = 4'd3; speed_y = 4'd2;
        for (int i = 0; i < 5; i++) begin
            enable = (i < 4);
            exp_q.push_back(32'(ex[i])); exp_q.push_back(32'(ey[i])); exp_q.push_back(32'd0);
            tick((i == 3) ? 4 : 0);
            e = exp_q.pop_front(); checks++;
            if (32'(xo[0]) !== e) begin errors++; $display("FAIL motion_x[%0d] got %0d want %0d", i, xo[0], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(yo[0]) !== e) begin errors++; $display("FAIL motion_y[%0d] got %0d want %0d", i, yo[0], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(bfirst[0]) !== e) begin errors++; $display("FAIL motion_bounce[%0d] got %0d want %0d", i, bfirst[0], e); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hcount = 11'(hs[i]); vcount = 10'd58;
            exp_q.push_back(32'(ps[i]));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (32'(pix[0]) !== e)
                begin errors++; $display("FAIL moved_pix[%0d] got %h want %h", i, pix[0], e); end
        end
        // reset coinciding with a vsync fall must discard the pending move
        @(negedge clk);
        hcount = 11'd500; enable = 1'b1; vsync = 1'b0; reset = 1'b1;
        exp_q.push_back(32'd100); exp_q.push_back(32'd50);
        @(posedge clk); #1;
        e = exp_q.pop_front(); checks++;
        if (32'(xo[0]) !== e) begin errors++; $display("FAIL midreset_x got %0d want %0d", xo[0], e); end
        e = exp_q.pop_front(); checks++;
        if (32'(yo[0]) !== e) begin errors++; $display("FAIL midreset_y got %0d want %0d", yo[0], e); end
        @(negedge clk);
        reset = 1'b0; vsync = 1'b1;
        exp_q.push_back(32'd100);
        @(posedge clk); #1;
        e = exp_q.pop_front(); checks++;
        if (32'(xo[0]) !== e) begin errors++; $display("FAIL midreset_hold_x got %0d want %0d", xo[0], e); end
    endtask

    task automatic test_right_bounce();
        int ex [2] = '{960, 956};
        int eb [2] = '{1, 0};
        do_reset();
        enable = 1'b1; speed_x = 4'd4; speed_y = 4'd0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'(ex[i])); exp_q.push_back(32'd0);
            exp_q.push_back(32'(eb[i])); exp_q.push_back(32'd0);
            tick(0);
            e = exp_q.pop_front(); checks++;
            if (32'(xo[1]) !== e) begin errors++; $display("FAIL rb_x[%0d] got %0d want %0d", i, xo[1], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(yo[1]) !== e) begin errors++; $display("FAIL rb_y[%0d] got %0d want %0d", i, yo[1], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(bfirst[1]) !== e) begin errors++; $display("FAIL rb_bounce[%0d] got %0d want %0d", i, bfirst[1], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(bsecond[1]) !== e) begin errors++; $display("FAIL rb_bounce_end[%0d] got %0d want %0d", i, bsecond[1], e); end
        end
    endtask

    task automatic test_corner();
        int ep [4] = '{10, 5, 0, 5};
        int eb [4] = '{1, 0, 1, 0};
        do_reset();
        enable = 1'b1; speed_x = 4'd5; speed_y = 4'd5;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(ep[i])); exp_q.push_back(32'(ep[i]));
            exp_q.push_back(32'(eb[i])); exp_q.push_back(32'd0);
            tick(0);
            e = exp_q.pop_front(); checks++;
            if (32'(xo[2]) !== e) begin errors++; $display("FAIL corner_x[%0d] got %0d want %0d", i, xo[2], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(yo[2]) !== e) begin errors++; $display("FAIL corner_y[%0d] got %0d want %0d", i, yo[2], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(bfirst[2]) !== e) begin errors++; $display("FAIL corner_bounce[%0d] got %0d want %0d", i, bfirst[2], e); end
            e = exp_q.pop_front(); checks++;
            if (32'(bsecond[2]) !== e) begin errors++; $display("FAIL corner_bounce_end[%0d] got %0d want %0d", i, bsecond[2], e); end
        end
    endtask

    // action: 0 = none, 1 = hit pulse, 2 = tick, 3 = hit and tick together
    task automatic test_flash();
        int          act [10] = '{0, 1, 2, 2, 2, 1, 2, 3, 2, 2};
        logic [23:0] ps  [10] = '{24'hFFFFFF, 24'hFF0000, 24'hFF0000, 24'hFFFFFF, 24'hFFFFFF,
                                  24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFFFFFF};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (act[i] == 2) begin
                tick(0);
            end else if (act[i] != 0) begin
                @(negedge clk);
                hit = 1'b1;
                vsync = (act[i] == 3) ? 1'b0 : 1'b1;
                @(negedge clk);
                hit = 1'b0; vsync = 1'b1;
            end
            @(negedge clk);
            hcount = 11'd10; vcount = 10'd10;
            exp_q.push_back(32'(ps[i]));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (32'(pix[3]) !== e)
                begin errors++; $display("FAIL flash_pix[%0d] got %h want %h", i, pix[3], e); end
        end
        @(negedge clk);
        hcount = 11'd70;
        exp_q.push_back(32'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); checks++;
        if (32'(pix[3]) !== e) begin errors++; $display("FAIL flash_outside got %h want %h", pix[3], e); end
    endtask

    task automatic test_outline();
        int          hs [7] = '{1, 2, 62, 61, 63, 64, 30};
        int          vs [7] = '{1, 2, 30, 30, 63, 0, 62};
        logic [23:0] ps [7] = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            hcount = 11'(hs[i]); vcount = 10'(vs[i]);
            exp_q.push_back(32'(ps[i]));
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (32'(pix[4]) !== e)
                begin errors++; $display("FAIL outline_pix[%0d] got %h want %h", i, pix[4], e); end
        end
    endtask

    initial begin
        test_reset();
        test_motion();
        test_right_bounce();
        test_corner();
        test_flash();
        test_outline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
